// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, runs the imem req/ready handshake and
// presents fetched instructions to IF/ID with a one-entry skid buffer.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exception,
    input  logic [31:0] exception_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc_out,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] drain_addr, drain_addr_n;
    logic        slot_valid, slot_valid_n;
    logic [31:0] slot_instr, slot_instr_n;
    logic [31:0] slot_pc, slot_pc_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] epc_q, epc_n;

    logic        redirect;
    logic        consume;
    logic [31:0] target;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_VECTOR;
            drain_addr <= '0;
            slot_valid <= 1'b0;
            slot_instr <= '0;
            slot_pc    <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            epc_q      <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drain_addr <= drain_addr_n;
            slot_valid <= slot_valid_n;
            slot_instr <= slot_instr_n;
            slot_pc    <= slot_pc_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            epc_q      <= epc_n;
        end
    end

    always_comb begin
        redirect = exception | branch_taken | jump;
        if (exception)         target = EXC_VECTOR;
        else if (branch_taken) target = branch_target;
        else                   target = jump_target;
        target[1:0] = 2'b00;
        consume = slot_valid & ~stall;

        state_n      = state;
        pc_n         = pc;
        drain_addr_n = drain_addr;
        slot_valid_n = slot_valid;
        slot_instr_n = slot_instr;
        slot_pc_n    = slot_pc;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        epc_n        = exception ? exception_pc : epc_q;

        case (state)
            S_FETCH: begin
                if (redirect) begin
                    slot_valid_n = 1'b0;
                    pc_n         = target;
                    if (!imem_ready) begin
                        // request already on the bus: keep its address until it completes
                        state_n      = S_DRAIN;
                        drain_addr_n = pc;
                    end
                end else if (imem_ready) begin
                    pc_n = pc + 32'd4;
                    if (!slot_valid || consume) begin
                        slot_valid_n = 1'b1;
                        slot_instr_n = imem_rdata;
                        slot_pc_n    = pc;
                    end else begin
                        skid_instr_n = imem_rdata;
                        skid_pc_n    = pc;
                        state_n      = S_HOLD;
                    end
                end else if (consume) begin
                    slot_valid_n = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    slot_valid_n = 1'b0;
                    pc_n         = target;
                    state_n      = S_FETCH;
                end else if (consume) begin
                    slot_instr_n = skid_instr;
                    slot_pc_n    = skid_pc;
                    state_n      = S_FETCH;
                end
            end
            S_DRAIN: begin
                slot_valid_n = 1'b0;
                if (redirect) pc_n = target;
                if (imem_ready) state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign imem_req    = ~reset & (state != S_HOLD);
    assign imem_addr   = (state == S_DRAIN) ? drain_addr : pc;
    assign if_valid    = slot_valid;
    assign if_instr    = slot_instr;
    assign if_pc       = slot_pc;
    assign pc_out      = pc;
    assign flush_if_id = redirect;
    assign flush_id_ex = branch_taken | exception;
    assign epc         = epc_q;

endmodule
